// File: rtl/snake_game_ctrl.sv
// Game-state controller for the VGA snake game: IDLE/PLAY/PAUSE/GAME_OVER FSM, step pacing, score, lives.
// Optional pause support is compiled in when GAME_PAUSE_EN is defined.
module snake_game_ctrl #(
  parameter int SCORE_W       = 8,
  parameter int LIVES         = 3,
  parameter int LIVES_W       = 2,
  parameter int PER_W         = 4,
  parameter int START_PERIOD  = 8,
  parameter int MIN_PERIOD    = 2,
  parameter int SPEEDUP_EVERY = 4,
  parameter int GO_HOLD       = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick_i,
  input  logic               btn_any_i,
  input  logic               btn_pause_i,
  input  logic               apple_hit_i,
  input  logic               collision_i,
  output logic [1:0]         state_o,
  output logic               step_pulse_o,
  output logic               apple_trigger_o,
  output logic               snake_reset_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [LIVES_W-1:0] lives_o
);

  localparam int AC_W   = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;
  localparam int HOLD_W = (GO_HOLD > 1) ? $clog2(GO_HOLD) : 1;

  localparam logic [PER_W-1:0]   START_P   = PER_W'(START_PERIOD);
  localparam logic [PER_W-1:0]   MIN_P     = PER_W'(MIN_PERIOD);
  localparam logic [LIVES_W-1:0] LIVES_L   = LIVES_W'(LIVES);
  localparam logic [LIVES_W-1:0] ONE_LIFE  = LIVES_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [AC_W-1:0]    AC_LAST   = AC_W'(SPEEDUP_EVERY - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(GO_HOLD - 1);

  if (START_PERIOD > (2 ** PER_W) - 1) begin : g_chk_start
    $error("START_PERIOD does not fit in PER_W bits");
  end
  if (MIN_PERIOD < 1 || MIN_PERIOD > START_PERIOD) begin : g_chk_min
    $error("MIN_PERIOD must be in 1..START_PERIOD");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_PAUSE = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [PER_W-1:0]   period_q, period_d;
  logic [PER_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [AC_W-1:0]    apple_cnt_q, apple_cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               apple_lat_q, apple_lat_d;
  logic               col_lat_q, col_lat_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               step_q, step_d;
  logic               trig_q, trig_d;
  logic               srst_q, srst_d;
  logic               any_prev_q;
  logic               any_edge, pause_go;
  logic               step_now, col_acc, app_acc;

  assign any_edge = btn_any_i & ~any_prev_q;

`ifdef GAME_PAUSE_EN
  logic pause_prev_q;
  assign pause_go = btn_pause_i & ~pause_prev_q;
`else
  logic unused_pause;
  assign unused_pause = btn_pause_i;
  assign pause_go     = 1'b0;
`endif

  // ">=" rather than "==" so a speed-up that lands with frame_cnt already at
  // the new period still steps on the next tick instead of wrapping the counter.
  assign step_now = frame_tick_i && (frame_cnt_q >= period_q - 1'b1);
  assign col_acc  = collision_i & ~col_lat_q;
  assign app_acc  = apple_hit_i & ~apple_lat_q & ~col_acc;

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    frame_cnt_d = frame_cnt_q;
    apple_cnt_d = apple_cnt_q;
    hold_d      = hold_q;
    apple_lat_d = apple_lat_q;
    col_lat_d   = col_lat_q;
    score_d     = score_q;
    lives_d     = lives_q;
    step_d      = 1'b0;
    trig_d      = 1'b0;
    srst_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_edge) begin
          state_d     = S_PLAY;
          score_d     = '0;
          lives_d     = LIVES_L;
          period_d    = START_P;
          frame_cnt_d = '0;
          apple_cnt_d = '0;
          apple_lat_d = 1'b0;
          col_lat_d   = 1'b0;
          srst_d      = 1'b1;
          trig_d      = 1'b1;
        end
      end

      S_PLAY: begin
        if (pause_go) begin
          state_d = S_PAUSE;
        end else begin
          if (frame_tick_i) frame_cnt_d = step_now ? '0 : frame_cnt_q + 1'b1;
          step_d = step_now;

          if (col_acc) begin
            col_lat_d = 1'b1;
            if (apple_hit_i) apple_lat_d = 1'b1;
            if (lives_q == ONE_LIFE) begin
              lives_d = '0;
              state_d = S_OVER;
              hold_d  = '0;
            end else begin
              lives_d     = lives_q - 1'b1;
              srst_d      = 1'b1;
              frame_cnt_d = '0;
            end
          end

          if (app_acc) begin
            apple_lat_d = 1'b1;
            trig_d      = 1'b1;
            if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
            if (apple_cnt_q == AC_LAST) begin
              apple_cnt_d = '0;
              period_d    = (period_q > MIN_P) ? period_q - 1'b1 : MIN_P;
            end else begin
              apple_cnt_d = apple_cnt_q + 1'b1;
            end
          end

          // A step opens a new interval: both hit latches re-arm.
          if (step_now) begin
            apple_lat_d = 1'b0;
            col_lat_d   = 1'b0;
          end
        end
      end

      S_PAUSE: begin
        if (pause_go) state_d = S_PLAY;
      end

      S_OVER: begin
        if (frame_tick_i) begin
          if (hold_q == HOLD_LAST) state_d = S_IDLE;
          else                     hold_d  = hold_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // Previous button levels track even through reset so a button held across
    // reset does not register as a fresh press.
    any_prev_q <= btn_any_i;
`ifdef GAME_PAUSE_EN
    pause_prev_q <= btn_pause_i;
`endif
    if (reset) begin
      state_q     <= S_IDLE;
      period_q    <= START_P;
      frame_cnt_q <= '0;
      apple_cnt_q <= '0;
      hold_q      <= '0;
      apple_lat_q <= 1'b0;
      col_lat_q   <= 1'b0;
      score_q     <= '0;
      lives_q     <= LIVES_L;
      step_q      <= 1'b0;
      trig_q      <= 1'b0;
      srst_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      frame_cnt_q <= frame_cnt_d;
      apple_cnt_q <= apple_cnt_d;
      hold_q      <= hold_d;
      apple_lat_q <= apple_lat_d;
      col_lat_q   <= col_lat_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      step_q      <= step_d;
      trig_q      <= trig_d;
      srst_q      <= srst_d;
    end
  end

  assign state_o         = state_q;
  assign step_pulse_o    = step_q;
  assign apple_trigger_o = trig_q;
  assign snake_reset_o   = srst_q;
  assign score_o         = score_q;
  assign lives_o         = lives_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed game scenarios plus random play, checked every cycle against a behavioural model.
module tb_snake_game_ctrl;

  localparam int SCORE_W = 8, LIVES = 3, LIVES_W = 2, START_PERIOD = 8;
  localparam int MIN_PERIOD = 2, SPEEDUP_EVERY = 4, GO_HOLD = 120;
  localparam int W = 5 + SCORE_W + LIVES_W;
`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic clk, reset;
  logic frame_tick, btn_any, btn_pause, apple_hit, collision;
  logic [1:0] state;
  logic step_pulse, apple_trigger, snake_reset;
  logic [SCORE_W-1:0] score;
  logic [LIVES_W-1:0] lives;

  int n_total = 0;
  int n_pass  = 0;
  logic [W-1:0] exp_q[$];

  snake_game_ctrl dut (
    .clk(clk), .reset(reset),
    .frame_tick_i(frame_tick), .btn_any_i(btn_any), .btn_pause_i(btn_pause),
    .apple_hit_i(apple_hit), .collision_i(collision),
    .state_o(state), .step_pulse_o(step_pulse), .apple_trigger_o(apple_trigger),
    .snake_reset_o(snake_reset), .score_o(score), .lives_o(lives)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  // Game-level view: step period follows from apples eaten this game,
  // frames are counted since the last step, score is apples clipped to max.
  int m_state = 0, m_apples = 0, m_lives = LIVES, m_fc = 0, m_hold = 0;
  bit m_al = 0, m_cl = 0, m_any_prev = 0, m_pause_prev = 0;

  function automatic int period_of(input int apples);
    int p;
    p = START_PERIOD - apples / SPEEDUP_EVERY;
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

  always @(posedge clk) begin
    bit any_e, pause_e, stp, trg, srs, c_ok, a_ok;
    int sc;
    any_e = btn_any && !m_any_prev;
    pause_e = btn_pause && !m_pause_prev;
    m_any_prev = btn_any;
    m_pause_prev = btn_pause;
    stp = 0; trg = 0; srs = 0;
    if (reset) begin
      m_state = 0; m_apples = 0; m_lives = LIVES; m_fc = 0; m_al = 0; m_cl = 0; m_hold = 0;
    end else if (m_state == 0) begin
      if (any_e) begin
        m_state = 1; m_apples = 0; m_lives = LIVES; m_fc = 0; m_al = 0; m_cl = 0;
        trg = 1; srs = 1;
      end
    end else if (m_state == 1) begin
      if (PAUSE_EN && pause_e) m_state = 2;
      else begin
        if (frame_tick) begin
          if (m_fc + 1 >= period_of(m_apples)) begin stp = 1; m_fc = 0; end
          else m_fc++;
        end
        c_ok = collision && !m_cl;
        a_ok = apple_hit && !m_al && !c_ok;
        if (c_ok) begin
          m_cl = 1;
          if (apple_hit) m_al = 1;
          if (m_lives == 1) begin m_lives = 0; m_state = 3; m_hold = 0; end
          else begin m_lives--; srs = 1; m_fc = 0; end
        end
        if (a_ok) begin m_al = 1; trg = 1; m_apples++; end
        if (stp) begin m_al = 0; m_cl = 0; end
      end
    end else if (m_state == 2) begin
      if (pause_e) m_state = 1;
    end else begin
      if (frame_tick) begin
        m_hold++;
        if (m_hold == GO_HOLD) m_state = 0;
      end
    end
    sc = (m_apples > 2 ** SCORE_W - 1) ? 2 ** SCORE_W - 1 : m_apples;
    exp_q.push_back({2'(m_state), stp, trg, srs, SCORE_W'(sc), LIVES_W'(m_lives)});
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, step_pulse, apple_trigger, snake_reset, score, lives};
      n_total++;
      if (a === e) n_pass++;
      else $display("FAIL model_cycle t=%0t actual(st,stp,trg,srs,score,lives)=%b,%b,%b,%b,%0d,%0d required=%b,%b,%b,%b,%0d,%0d",
                    $time, a[W-1 -: 2], a[W-3], a[W-4], a[W-5], a[LIVES_W +: SCORE_W], a[LIVES_W-1:0],
                    e[W-1 -: 2], e[W-3], e[W-4], e[W-5], e[LIVES_W +: SCORE_W], e[LIVES_W-1:0]);
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  // ---------------- drivers ----------------
  // Drive one cycle of pulse inputs; on return the outputs reflect them.
  task automatic cyc(input bit ft, input bit ah, input bit co);
    frame_tick = ft; apple_hit = ah; collision = co;
    @(negedge clk);
  endtask

  // Tick frames (one idle cycle between ticks) until a step; returns tick count, -1 on timeout.
  task automatic spacing(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc(1, 0, 0);
      if (step_pulse) begin n = i; break; end
      cyc(0, 0, 0);
    end
    if (n != -1) cyc(0, 0, 0);
  endtask

  task automatic eat_and_measure(output int n);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    spacing(n);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n, steps, first_t, last_t, trigs;
    reset = 1; frame_tick = 0; btn_any = 0; btn_pause = 0; apple_hit = 0; collision = 0;
    @(negedge clk);
    repeat (3) cyc(0, 0, 0);
    reset = 0;
    cyc(0, 0, 0);
    check("reset_state", state, 0);
    check("reset_score", score, 0);
    check("reset_lives", lives, 3);

    btn_any = 1;
    cyc(0, 0, 0);
    check("start_state", state, 1);
    check("start_snake_reset", snake_reset, 1);
    check("start_apple_trigger", apple_trigger, 1);
    check("start_lives", lives, 3);
    cyc(0, 0, 0);
    check("start_pulse_width", snake_reset + apple_trigger, 0);

    steps = 0; first_t = 0; last_t = 0;
    for (int t = 1; t <= 16; t++) begin
      cyc(1, 0, 0);
      if (step_pulse) begin
        steps++;
        if (first_t == 0) first_t = t;
        last_t = t;
      end
      cyc(0, 0, 0);
    end
    check("steps_in_16", steps, 2);
    check("first_step_tick", first_t, 8);
    check("second_step_tick", last_t, 16);

    trigs = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(0, 1, 0);
      trigs += apple_trigger;
    end
    cyc(0, 0, 0);
    check("held_apple_triggers", trigs, 1);
    check("held_apple_score", score, 1);
    spacing(n);
    check("spacing_1_apple", n, 8);
    for (int k = 2; k <= 4; k++) eat_and_measure(n);
    check("spacing_4_apples", n, 7);
    check("score_4", score, 4);
    for (int k = 5; k <= 40; k++) eat_and_measure(n);
    check("spacing_40_apples", n, 2);
    check("score_40", score, 40);

    cyc(0, 0, 1);
    check("col1_lives", lives, 2);
    check("col1_snake_reset", snake_reset, 1);
    check("col1_state", state, 1);
    cyc(0, 0, 1);
    check("col_latched_lives", lives, 2);
    cyc(0, 0, 0);
    spacing(n);
    cyc(0, 1, 1);
    check("both_lives", lives, 1);
    check("both_score", score, 40);
    check("both_no_trigger", apple_trigger, 0);
    cyc(0, 0, 0);
    spacing(n);
    cyc(0, 0, 1);
    check("col3_state", state, 3);
    check("col3_lives", lives, 0);
    cyc(0, 0, 0);

    steps = 0;
    for (int i = 1; i < GO_HOLD; i++) begin
      btn_any = i[0];
      cyc(1, 1, 1);
      steps += step_pulse;
      cyc(0, 0, 0);
    end
    check("go_hold_state", state, 3);
    check("go_no_steps", steps, 0);
    btn_any = 0;
    cyc(1, 0, 0);
    check("go_exit_state", state, 0);
    check("go_score_kept", score, 40);
    cyc(0, 0, 0);

    // new game; pause behaviour (or its absence)
    btn_any = 1;
    cyc(0, 0, 0);
    for (int i = 0; i < 3; i++) begin cyc(1, 0, 0); cyc(0, 0, 0); end
    btn_pause = 1;
    cyc(0, 0, 0);
    if (PAUSE_EN) begin
      check("pause_state", state, 2);
      steps = 0;
      for (int i = 0; i < 20; i++) begin
        cyc(1, 1, 0);
        steps += step_pulse;
      end
      check("pause_no_steps", steps, 0);
      check("pause_score", score, 0);
      btn_pause = 0;
      cyc(0, 0, 0);
      btn_pause = 1;
      cyc(0, 0, 0);
      check("resume_state", state, 1);
      btn_pause = 0;
      spacing(n);
      check("resume_spacing", n, 5);
    end else begin
      check("no_pause_state", state, 1);
      btn_pause = 0;
      spacing(n);
      check("no_pause_spacing", n, 5);
    end

    // reset mid-game with btn_any held: abort, no restart afterwards
    cyc(0, 1, 0);
    reset = 1;
    cyc(1, 1, 1);
    check("midreset_state", state, 0);
    check("midreset_score", score, 0);
    check("midreset_pulses", step_pulse + apple_trigger + snake_reset, 0);
    reset = 0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("post_reset_state", state, 0);
    check("post_reset_pulses", apple_trigger + snake_reset, 0);

    // random play against the model
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 9) == 0) btn_any = ~btn_any;
      if ($urandom_range(0, 39) == 0) btn_pause = ~btn_pause;
      reset = ($urandom_range(0, 1999) == 0);
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0);
    end
    reset = 0;
    cyc(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
